alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Registered ALU operand-select stage for the pipelined RISC-V core; successor to the combinational SrcB mux.
//  Resolves RAW hazards by forwarding from NUM_FWD younger stages, selects SrcA (rs1/PC/zero) and SrcB (rs2/imm).
//  Captures operands into a one-entry output register with a valid/ready handshake and flush.
//  Sits between the decode/register-read stage and the ALU/execute stage.
// PARAMETERS
//  XLEN       32  datapath width of operands, immediates, PC and forwarded data
//  NUM_FWD    2   number of forwarding sources; index 0 = youngest (EX/MEM), highest = oldest (WB)
//  REG_ADDR_W 5   register index width
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous active-low reset
//  in_valid   in   1                  upstream operands/controls valid
//  in_ready   out  1                  stage can accept this cycle
//  rs1_addr   in   REG_ADDR_W         source register 1 index
//  rs2_addr   in   REG_ADDR_W         source register 2 index
//  rs1_data   in   XLEN               register-file read data 1
//  rs2_data   in   XLEN               register-file read data 2
//  imm_ext    in   XLEN               sign-extended immediate
//  pc         in   XLEN               instruction PC
//  alu_src_a  in   2                  srca_sel_e: RS1=0, PC=1, ZERO=2 (3 reserved -> ZERO)
//  alu_src_b  in   1                  srcb_sel_e: RS2=0, IMM=1
//  fwd_valid  in   NUM_FWD            forwarding source i writes a register
//  fwd_rd     in   NUM_FWD*REG_ADDR_W destination index per source (slice i)
//  fwd_data   in   NUM_FWD*XLEN       result per source (slice i)
//  flush      in   1                  kill held and incoming operation
//  out_valid  out  1                  src_a/src_b/store_data valid
//  out_ready  in   1                  downstream accepts
//  src_a      out  XLEN               registered ALU operand A
//  src_b      out  XLEN               registered ALU operand B
//  store_data out  XLEN               registered forwarded rs2 (store data, independent of alu_src_b)
//  fwd_hit    out  2                  registered {rs2 forwarded, rs1 forwarded}, for perf counters
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, src_a=src_b=store_data=0, fwd_hit=0; in_ready=1 after release.
//  - Forwarding, per operand, combinational on inputs: lowest index i with fwd_valid[i] && fwd_rd[i]==rsX_addr
//    && rsX_addr!=0 wins; with no match, rsX_data. x0 always reads 0, never forwarded, even if rs1_data!=0.
//  - Select: A = fwdRS1 | pc | 0; B = fwdRS2 | imm_ext. store_data = fwdRS2 always.
//  - in_ready = !out_valid || out_ready (no combinational path from in_valid). Load when in_valid && in_ready.
//  - Latency 1 cycle: operands sampled at edge k appear at outputs after edge k, out_valid=1.
//  - out_valid && !out_ready: all outputs hold stable; no input sampled.
//  - out_valid && out_ready && !in_valid: out_valid->0 next cycle; data regs hold last value.
//  - flush=1: out_valid->0 next edge; no load that cycle regardless of in_valid (flush beats load).
//  - Data regs load only on accept; out_valid is the only control state (2-state: EMPTY, FULL).
//  - Width: all muxing at XLEN; no arithmetic. Reset mid-operation drops held operation, no residue.
// STRUCTURE
//  - alu_pkg: srca_sel_e, srcb_sel_e enums; SRCA_W=2, SRCB_W=1 constants; shared with decoder/control.
//  - Sub-module fwd_select (params XLEN, NUM_FWD, REG_ADDR_W; combinational priority match),
//    instantiated twice (rs1, rs2); this module holds the select muxes and output register.
// TESTING
//  1 Reset: rst_n=0 mid-run with out_valid=1 -> out_valid=0, src_a=src_b=0 immediately (before next edge).
//  2 No hazard: rs2_data=1234BEEF, imm_ext=4321FEEB, alu_src_b=RS2 -> src_b=1234BEEF one cycle later;
//    alu_src_b=IMM -> src_b=4321FEEB; store_data=1234BEEF both cases.
//  3 Priority: rs1_addr=5, fwd0={v,5,10001000}, fwd1={v,5,20002000} -> src_a=10001000, fwd_hit[0]=1;
//    drop fwd_valid[0] -> src_a=20002000.
//  4 x0: rs1_addr=0, rs1_data=DEADBEEF, fwd0={v,0,FFFFFFFF}, alu_src_a=RS1 -> src_a=00000000, fwd_hit=0.
//  5 Backpressure: out_ready=0 two cycles while in_valid toggles -> in_ready=0, outputs stable;
//    out_ready=1 -> next op loads same cycle as drain (back-to-back, no bubble).
//  6 Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, new operands not captured.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared ALU operand-select encodings for the pipelined RISC-V core.
//   The decoder, control logic and the operand stage all use these.
//
//   Contents:
//     SRCA_W / SRCB_W  widths of the operand-select control fields
//     srca_sel_e       operand A source: RS1, PC or ZERO (encoding 3 is reserved
//                      and decodes as ZERO)
//     srcb_sel_e       operand B source: RS2 or IMM
//     stage_state_e    occupancy of the one-entry operand register
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int SRCA_W = 2;
    localparam int SRCB_W = 1;

    typedef enum logic [SRCA_W-1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } srca_sel_e;

    typedef enum logic [SRCB_W-1:0] {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } srcb_sel_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage : alu_pkg

// File: rtl/alu_operand_stage_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Combinational operand forwarding for one source register. Source i wins
//   when it is valid and targets the requested register. If several sources
//   match, the lowest index wins, because index 0 is the youngest producer.
//   Register x0 always reads as zero and is never forwarded.
//
//   Ports:
//     i_rs_addr    source register index
//     i_rs_data    register-file read data for i_rs_addr
//     i_fwd_valid  per-source "writes a register" flag
//     i_fwd_rd     per-source destination index, slice i
//     i_fwd_data   per-source result, slice i
//     o_data       resolved operand value
//     o_hit        operand was taken from a forwarding source
// -----------------------------------------------------------------------------
module fwd_select #(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0]         i_rs_addr,
    input  logic [XLEN-1:0]               i_rs_data,
    input  logic [NUM_FWD-1:0]            i_fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]       i_fwd_data,
    output logic [XLEN-1:0]               o_data,
    output logic                          o_hit
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and no latch is inferred.
    always_comb begin
        o_data = i_rs_data;
        o_hit  = 1'b0;
        if (i_rs_addr == '0) begin
            // x0 reads zero, even if the register file returns something else.
            o_data = '0;
        end else begin
            // Walk from oldest to youngest. A later (younger) match overwrites
            // an earlier one, so the lowest matching index wins.
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (i_fwd_valid[i] &&
                    (i_fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == i_rs_addr)) begin
                    o_data = i_fwd_data[i*XLEN +: XLEN];
                    o_hit  = 1'b1;
                end
            end
        end
    end

endmodule : fwd_select

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Registered ALU operand-select stage. It sits between decode/register-read
//   and execute. rs1 and rs2 are resolved through forwarding, then operand A
//   (rs1/PC/zero) and operand B (rs2/immediate) are selected. The results are
//   captured in a one-entry output register with a valid/ready handshake and
//   a flush.
//
//   Ports:
//     clk, rst_n                clock, asynchronous active-low reset
//     in_valid / in_ready       upstream handshake. in_ready does not depend
//                               on in_valid.
//     rs1_addr, rs2_addr        source register indices
//     rs1_data, rs2_data        register-file read data
//     imm_ext, pc               sign-extended immediate, instruction PC
//     alu_src_a, alu_src_b      operand select (srca_sel_e / srcb_sel_e)
//     fwd_valid/fwd_rd/fwd_data forwarding sources. Index 0 is the youngest.
//     flush                     kills the held and the incoming operation
//     out_valid / out_ready     downstream handshake
//     src_a, src_b              registered ALU operands
//     store_data                registered forwarded rs2, independent of
//                               alu_src_b
//     fwd_hit                   registered {rs2 forwarded, rs1 forwarded}
// -----------------------------------------------------------------------------
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]               rs1_data,
    input  logic [XLEN-1:0]               rs2_data,
    input  logic [XLEN-1:0]               imm_ext,
    input  logic [XLEN-1:0]               pc,
    input  logic [SRCA_W-1:0]             alu_src_a,
    input  logic [SRCB_W-1:0]             alu_src_b,

    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,

    input  logic                          flush,

    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               src_a,
    output logic [XLEN-1:0]               src_b,
    output logic [XLEN-1:0]               store_data,
    output logic [1:0]                    fwd_hit
);

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic            w_rs1_hit;
    logic            w_rs2_hit;

    fwd_select #(
        .XLEN       (XLEN),
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .i_rs_addr   (rs1_addr),
        .i_rs_data   (rs1_data),
        .i_fwd_valid (fwd_valid),
        .i_fwd_rd    (fwd_rd),
        .i_fwd_data  (fwd_data),
        .o_data      (w_rs1_fwd),
        .o_hit       (w_rs1_hit)
    );

    fwd_select #(
        .XLEN       (XLEN),
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .i_rs_addr   (rs2_addr),
        .i_rs_data   (rs2_data),
        .i_fwd_valid (fwd_valid),
        .i_fwd_rd    (fwd_rd),
        .i_fwd_data  (fwd_data),
        .o_data      (w_rs2_fwd),
        .o_hit       (w_rs2_hit)
    );

    // ------------------------------------------------------------------
    // Operand select
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_src_b;

    always_comb begin
        w_src_a = '0;
        case (srca_sel_e'(alu_src_a))
            SRCA_RS1: w_src_a = w_rs1_fwd;
            SRCA_PC:  w_src_a = pc;
            default:  w_src_a = '0;   // ZERO and the reserved encoding
        endcase
    end

    assign w_src_b = (srcb_sel_e'(alu_src_b) == SRCB_IMM) ? imm_ext : w_rs2_fwd;

    // ------------------------------------------------------------------
    // Occupancy control: EMPTY / FULL
    // ------------------------------------------------------------------
    stage_state_e r_state;
    stage_state_e w_state_nxt;
    logic         w_load;

    // The register can take a new operation when it is empty or is being
    // drained this cycle. Taking a new op while draining gives back-to-back
    // flow with no bubble.
    assign in_ready = (r_state == ST_EMPTY) || out_ready;

    // Flush wins over load, so a flushed cycle captures nothing.
    assign w_load   = in_valid && in_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_load) begin
            w_state_nxt = ST_FULL;
        end else if (out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and simulation ordering cannot create races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Operand register. It loads only on accept. At other times, including
    // after a drain, it keeps the last value.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_src_a;
    logic [XLEN-1:0] r_src_b;
    logic [XLEN-1:0] r_store_data;
    logic [1:0]      r_fwd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_store_data <= '0;
            r_fwd_hit    <= '0;
        end else if (w_load) begin
            r_src_a      <= w_src_a;
            r_src_b      <= w_src_b;
            r_store_data <= w_rs2_fwd;
            r_fwd_hit    <= {w_rs2_hit, w_rs1_hit};
        end
    end

    assign out_valid  = (r_state == ST_FULL);
    assign src_a      = r_src_a;
    assign src_b      = r_src_b;
    assign store_data = r_store_data;
    assign fwd_hit    = r_fwd_hit;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//   Directed-vector bench for alu_operand_stage. Each accepted operation pushes
//   its hand-computed expected result into a queue. A monitor pops and compares
//   one entry whenever the DUT hands an operation downstream
//   (out_valid && out_ready). Reset, backpressure and flush behaviour are
//   checked directly from the stimulus thread.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int XLEN       = 32;
    localparam int NUM_FWD    = 2;
    localparam int REG_ADDR_W = 5;

    logic                          clk;
    logic                          rst_n;
    logic                          in_valid;
    logic                          in_ready;
    logic [REG_ADDR_W-1:0]         rs1_addr;
    logic [REG_ADDR_W-1:0]         rs2_addr;
    logic [XLEN-1:0]               rs1_data;
    logic [XLEN-1:0]               rs2_data;
    logic [XLEN-1:0]               imm_ext;
    logic [XLEN-1:0]               pc;
    logic [SRCA_W-1:0]             alu_src_a;
    logic [SRCB_W-1:0]             alu_src_b;
    logic [NUM_FWD-1:0]            fwd_valid;
    logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0]       fwd_data;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [XLEN-1:0]               src_a;
    logic [XLEN-1:0]               src_b;
    logic [XLEN-1:0]               store_data;
    logic [1:0]                    fwd_hit;

    alu_operand_stage #(
        .XLEN       (XLEN),
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm_ext    (imm_ext),
        .pc         (pc),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .store_data (store_data),
        .fwd_hit    (fwd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pcv;
        logic [1:0]  sa;
        logic        sb;
        logic [1:0]  fv;
        logic [9:0]  frd;
        logic [63:0] fdata;
    } stim_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [1:0]  hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic [4:0] rs1a, input logic [4:0] rs2a,
                                 input logic [31:0] rs1d, input logic [31:0] rs2d,
                                 input logic [1:0] sa, input logic sb,
                                 input logic [1:0] fv, input logic [4:0] frd1,
                                 input logic [4:0] frd0, input logic [31:0] fd1,
                                 input logic [31:0] fd0);
        stim_t s;
        s.rs1a  = rs1a;
        s.rs2a  = rs2a;
        s.rs1d  = rs1d;
        s.rs2d  = rs2d;
        s.imm   = 32'h4321_FEEB;
        s.pcv   = 32'h0000_1000;
        s.sa    = sa;
        s.sb    = sb;
        s.fv    = fv;
        s.frd   = {frd1, frd0};
        s.fdata = {fd1, fd0};
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sd, input logic [1:0] hit);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.sd  = sd;
        e.hit = hit;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rs1_addr  = s.rs1a;
        rs2_addr  = s.rs2a;
        rs1_data  = s.rs1d;
        rs2_data  = s.rs2d;
        imm_ext   = s.imm;
        pc        = s.pcv;
        alu_src_a = s.sa;
        alu_src_b = s.sb;
        fwd_valid = s.fv;
        fwd_rd    = s.frd;
        fwd_data  = s.fdata;
    endtask

    // Present one operation and hold it until the DUT accepts it. Accepted
    // operations queue their expected result.
    task automatic send(input stim_t s, input exp_t e);
        bit acc;
        bit rdy;
        acc = 1'b0;
        apply(s);
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1;
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1'b1;
        end
        if (acc) begin
            exp_q.push_back(e);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready never high within 20 cycles at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    // Monitor: compare every operation handed downstream.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: src_a=%h with empty scoreboard at %0t",
                             src_a, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("mon_src_a",      src_a,      mon_e.a);
                    check("mon_src_b",      src_b,      mon_e.b);
                    check("mon_store_data", store_data, mon_e.sd);
                    check("mon_fwd_hit",    fwd_hit,    mon_e.hit);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    stim_t s_p;
    stim_t s_q;
    exp_t  e_p;
    exp_t  e_q;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        apply(mk(5'd0, 5'd0, 32'h0, 32'h0, SRCA_RS1, SRCB_RS2, 2'b00,
                 5'd0, 5'd0, 32'h0, 32'h0));

        // Reset state
        #2;
        check("rst_out_valid",  out_valid,  0);
        check("rst_src_a",      src_a,      0);
        check("rst_src_b",      src_b,      0);
        check("rst_store_data", store_data, 0);
        check("rst_fwd_hit",    fwd_hit,    0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // No hazard: rs2 vs immediate, then PC / zero / reserved select for A
        send(mk(5'd1, 5'd2, 32'h0000_0011, 32'h1234_BEEF, SRCA_RS1, SRCB_RS2, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0),
             ex(32'h0000_0011, 32'h1234_BEEF, 32'h1234_BEEF, 2'b00));
        send(mk(5'd1, 5'd2, 32'h0000_0011, 32'h1234_BEEF, SRCA_RS1, SRCB_IMM, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0),
             ex(32'h0000_0011, 32'h4321_FEEB, 32'h1234_BEEF, 2'b00));
        send(mk(5'd1, 5'd2, 32'h0000_0011, 32'h1234_BEEF, SRCA_PC, SRCB_IMM, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0),
             ex(32'h0000_1000, 32'h4321_FEEB, 32'h1234_BEEF, 2'b00));
        send(mk(5'd1, 5'd2, 32'h0000_0011, 32'h1234_BEEF, SRCA_ZERO, SRCB_RS2, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0),
             ex(32'h0000_0000, 32'h1234_BEEF, 32'h1234_BEEF, 2'b00));
        send(mk(5'd1, 5'd2, 32'h0000_0011, 32'h1234_BEEF, 2'd3, SRCB_RS2, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0),
             ex(32'h0000_0000, 32'h1234_BEEF, 32'h1234_BEEF, 2'b00));

        // Priority: both sources target x5, so the youngest (index 0) wins
        send(mk(5'd5, 5'd6, 32'h5555_5555, 32'h6666_6666, SRCA_RS1, SRCB_RS2, 2'b11,
                5'd5, 5'd5, 32'h2000_2000, 32'h1000_1000),
             ex(32'h1000_1000, 32'h6666_6666, 32'h6666_6666, 2'b01));
        send(mk(5'd5, 5'd6, 32'h5555_5555, 32'h6666_6666, SRCA_RS1, SRCB_RS2, 2'b10,
                5'd5, 5'd5, 32'h2000_2000, 32'h1000_1000),
             ex(32'h2000_2000, 32'h6666_6666, 32'h6666_6666, 2'b01));
        // rs1 from source 0, rs2 from source 1. Store data is forwarded even with B=IMM.
        send(mk(5'd3, 5'd7, 32'h3333_3333, 32'h7777_7777, SRCA_RS1, SRCB_IMM, 2'b11,
                5'd7, 5'd3, 32'hAAAA_0001, 32'hBBBB_0002),
             ex(32'hBBBB_0002, 32'h4321_FEEB, 32'hAAAA_0001, 2'b11));
        // Sources valid but targeting other registers, so no forwarding
        send(mk(5'd9, 5'd10, 32'h9999_0009, 32'hA0A0_000A, SRCA_RS1, SRCB_RS2, 2'b11,
                5'd8, 5'd8, 32'hEEEE_EEEE, 32'hDDDD_DDDD),
             ex(32'h9999_0009, 32'hA0A0_000A, 32'hA0A0_000A, 2'b00));

        // x0: never forwarded, and reads zero despite nonzero register data
        send(mk(5'd0, 5'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, SRCA_RS1, SRCB_RS2, 2'b01,
                5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF),
             ex(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'b00));

        repeat (3) @(posedge clk);
        #1;

        // Backpressure: hold P for two cycles while in_valid toggles, then
        // drain P and load Q on the same edge.
        s_p = mk(5'd11, 5'd12, 32'h1111_AAAA, 32'h2222_BBBB, SRCA_RS1, SRCB_RS2, 2'b00,
                 5'd0, 5'd0, 32'h0, 32'h0);
        e_p = ex(32'h1111_AAAA, 32'h2222_BBBB, 32'h2222_BBBB, 2'b00);
        s_q = mk(5'd13, 5'd14, 32'h3333_CCCC, 32'h4444_DDDD, SRCA_RS1, SRCB_IMM, 2'b01,
                 5'd0, 5'd13, 32'h0, 32'h5A5A_5A5A);
        e_q = ex(32'h5A5A_5A5A, 32'h4321_FEEB, 32'h4444_DDDD, 2'b01);
        out_ready = 1'b0;
        send(s_p, e_p);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready",  in_ready,  0);
        for (int c = 0; c < 2; c++) begin
            apply(mk(5'd15, 5'd16, 32'h7777_7777, 32'h8888_8888, SRCA_PC, SRCB_IMM, 2'b11,
                     5'd15, 5'd16, 32'h9999_9999, 32'h6666_6666));
            in_valid = (c == 0);
            @(posedge clk);
            #1;
            check("bp_hold_in_ready",   in_ready,   0);
            check("bp_hold_out_valid",  out_valid,  1);
            check("bp_hold_src_a",      src_a,      e_p.a);
            check("bp_hold_src_b",      src_b,      e_p.b);
            check("bp_hold_store_data", store_data, e_p.sd);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(s_q, e_q);
        check("b2b_out_valid", out_valid, 1);
        check("b2b_src_a",     src_a,     e_q.a);

        repeat (3) @(posedge clk);
        #1;

        // Flush with the stage empty and in_valid high: nothing is captured
        apply(s_p);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        check("flush_empty_out_valid", out_valid, 0);
        in_valid = 1'b0;
        flush    = 1'b0;

        // Flush with an op held and a new op offered: both are dropped
        out_ready = 1'b0;
        send(s_q, e_q);
        apply(s_p);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        check("flush_full_out_valid", out_valid, 0);
        check("flush_no_capture_a",   src_a,     e_q.a);
        void'(exp_q.pop_back());
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("flush_stays_empty", out_valid, 0);

        // Asynchronous reset with an op held: cleared before the next edge
        out_ready = 1'b0;
        send(mk(5'd4, 5'd6, 32'h1357_2468, 32'h0BAD_F00D, SRCA_RS1, SRCB_RS2, 2'b01,
                5'd0, 5'd6, 32'h0, 32'h0246_8ACE),
             ex(32'h1357_2468, 32'h0246_8ACE, 32'h0246_8ACE, 2'b10));
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid",  out_valid,  0);
        check("arst_src_a",      src_a,      0);
        check("arst_src_b",      src_b,      0);
        check("arst_store_data", store_data, 0);
        check("arst_fwd_hit",    fwd_hit,    0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_post_out_valid", out_valid, 0);
        check("arst_post_in_ready",  in_ready,  1);

        // Normal operation after reset
        send(mk(5'd2, 5'd3, 32'hFEED_0001, 32'hFEED_0002, SRCA_RS1, SRCB_RS2, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0),
             ex(32'hFEED_0001, 32'hFEED_0002, 32'hFEED_0002, 2'b00));

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_operand_stage
